// File: rtl/axis_frame_demux.sv
// axis_frame_demux: frame-aware 1-to-M AXI-Stream demultiplexer.
// The destination is taken from tdest on the first beat of each frame and held
// until tlast. Frames whose destination is out of range are consumed and
// discarded. One registered output stage feeds all M_COUNT master ports.
// Optional build macro AXIS_FRAME_DEMUX_DROP_COUNT_EN adds a saturating 16-bit
// drop_count output that counts discarded frames.
module axis_frame_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 1,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 3,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser
`ifdef AXIS_FRAME_DEMUX_DROP_COUNT_EN
  ,
  output logic [15:0]                      drop_count
`endif
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [DEST_WIDTH:0] M_COUNT_EXT = (DEST_WIDTH + 1)'(M_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [M_COUNT-1:0]      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [KEEP_WIDTH-1:0]   keep_q, keep_d;
  logic                    last_q, last_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;

  logic                    out_ready_s;
  logic                    dest_ok_s;
  logic                    s_ready_s;
  logic                    accept_s;
  logic                    first_s;

  // The output register can take a beat when the selected port is empty or draining.
  assign out_ready_s = !valid_q[sel_q] || m_axis_tready[sel_q];
  assign dest_ok_s   = ({1'b0, s_axis_tdest} < M_COUNT_EXT);

  // Ready is forced low while reset is held so nothing is handshaken in reset.
  assign s_axis_tready = s_ready_s & ~rst;

  // Next-state, slave ready and output register update.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    data_d    = data_q;
    keep_d    = keep_q;
    last_d    = last_q;
    id_d      = id_q;
    dest_d    = dest_q;
    user_d    = user_q;
    s_ready_s = 1'b0;
    accept_s  = 1'b0;
    first_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && s_axis_tvalid) begin
          if (dest_ok_s) begin
            // A new frame waits until the previous port's beat can leave.
            s_ready_s = out_ready_s;
            if (out_ready_s) begin
              accept_s = 1'b1;
              first_s  = 1'b1;
              sel_d    = s_axis_tdest[SEL_W-1:0];
              state_d  = s_axis_tlast ? ST_IDLE : ST_FWD;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_ready_s = 1'b1;
            state_d   = s_axis_tlast ? ST_IDLE : ST_DROP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FWD: begin
        s_ready_s = out_ready_s;
        if (s_axis_tvalid && out_ready_s) begin
          accept_s = 1'b1;
          state_d  = s_axis_tlast ? ST_IDLE : ST_FWD;
        end else begin
          state_d = ST_FWD;
        end
      end
      ST_DROP: begin
        s_ready_s = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      // Old beat is empty or leaving this cycle, so only the new port is valid.
      valid_d        = '0;
      valid_d[sel_d] = 1'b1;
      data_d         = s_axis_tdata;
      keep_d         = s_axis_tkeep;
      last_d         = s_axis_tlast;
      id_d           = s_axis_tid;
      user_d         = s_axis_tuser;
      if (first_s) begin
        dest_d = s_axis_tdest;
      end else begin
        dest_d = dest_q;
      end
    end else if (valid_q[sel_q] && m_axis_tready[sel_q]) begin
      valid_d[sel_q] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      valid_q <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
      dest_q  <= '0;
      user_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      id_q    <= id_d;
      dest_q  <= dest_d;
      user_q  <= user_d;
    end
  end

  // Payload is broadcast; only the valid bit distinguishes the target port.
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = {M_COUNT{data_q}};
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? {M_COUNT{keep_q}} : '1;
  assign m_axis_tlast  = {M_COUNT{last_q}};
  assign m_axis_tid    = (ID_ENABLE != 0) ? {M_COUNT{id_q}} : '0;
  assign m_axis_tdest  = {M_COUNT{dest_q}};
  assign m_axis_tuser  = {M_COUNT{user_q}};

`ifdef AXIS_FRAME_DEMUX_DROP_COUNT_EN
  logic        drop_start_s;
  logic [15:0] drop_count_q, drop_count_d;

  // A drop is counted when the first beat of an out-of-range frame is consumed.
  assign drop_start_s = (state_q == ST_IDLE) && enable && s_axis_tvalid && !dest_ok_s;

  // Saturating dropped-frame counter.
  always_comb begin
    if (drop_start_s && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end else begin
      drop_count_d = drop_count_q;
    end
  end

  // Dropped-frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: doc/axis_frame_demux.md
Name: axis_frame_demux

Overview:
- Frame-aware 1-to-M AXI-Stream demultiplexer; the fan-out counterpart to the many-to-one arbitrated switch path.
- Routes each whole frame to the master port selected by tdest on its first beat.
- Holds the selection until tlast and drops frames with out-of-range destinations.
- Sits behind a single upstream stream, feeding M_COUNT downstream consumers through one registered output stage.

Parameters:
M_COUNT, 4, number of master output ports (>=2)
DATA_WIDTH, 8, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), tkeep carried when 1, otherwise m_axis_tkeep is all ones
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
ID_ENABLE, 1, tid carried when 1, otherwise m_axis_tid is 0
ID_WIDTH, 8, tid width
DEST_WIDTH, 3, tdest width; must be >= $clog2(M_COUNT)
USER_WIDTH, 1, tuser width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
enable  input  1  allows a new frame to start when high
s_axis_tdata  input  DATA_WIDTH  slave data
s_axis_tkeep  input  KEEP_WIDTH  slave keep
s_axis_tvalid  input  1  slave valid
s_axis_tready  output  1  slave ready
s_axis_tlast  input  1  slave last
s_axis_tid  input  ID_WIDTH  slave id
s_axis_tdest  input  DEST_WIDTH  slave destination
s_axis_tuser  input  USER_WIDTH  slave user
m_axis_tdata  output  M_COUNT*DATA_WIDTH  per-port data, all slices carry the same value
m_axis_tkeep  output  M_COUNT*KEEP_WIDTH  per-port keep
m_axis_tvalid  output  M_COUNT  per-port valid, at most one bit high
m_axis_tready  input  M_COUNT  per-port ready
m_axis_tlast  output  M_COUNT  per-port last
m_axis_tid  output  M_COUNT*ID_WIDTH  per-port id
m_axis_tdest  output  M_COUNT*DEST_WIDTH  per-port dest (latched frame dest)
m_axis_tuser  output  M_COUNT*USER_WIDTH  per-port user

Behaviour:
- Reset, asynchronous: state=IDLE, sel=0, all m_axis_tvalid=0, data/last/id/dest/user registers=0, s_axis_tready=0 while rst is high.
- FSM states:
  - IDLE: s_axis_tready=0 unless enable=1 and s_axis_tvalid=1.
    - On a first beat with tdest<M_COUNT: sel<=tdest; the beat is handled as in FWD.
    - If that beat has tlast, stay in IDLE; else go to FWD.
    - On a first beat with tdest>=M_COUNT: the beat is consumed (tready=1, no output).
    - If that beat has tlast, stay in IDLE; else go to DROP.
  - FWD: s_axis_tready = out_ready, where out_ready = !m_axis_tvalid[sel] | m_axis_tready[sel].
    - Accepted beat goes to the output register. tlast accepted -> IDLE.
    - tdest on non-first beats is ignored.
  - DROP: s_axis_tready=1 and all beats are discarded; tlast accepted -> IDLE.
- enable is sampled only in IDLE; deasserting it mid-frame does not stall the frame.
- Output register, one stage:
  - Latency s->m is 1 cycle.
  - On accept: m_axis_tvalid[sel]<=1 and the payload registers are loaded.
  - When m_axis_tready[sel] is high and there is no new accept, the valid bit clears.
  - Full throughput: a new beat is accepted in the same cycle the old one drains.
- Frame start in IDLE also requires out_ready for the old sel.
  - The output register drains to the previous port before the new frame's first beat is accepted.
  - At most one m_axis_tvalid bit is high at any time.
- Back-to-back frames: tlast in cycle N, next frame's first beat acceptable in N+1 when the register can drain.
- m_axis_tvalid, once high, stays high with stable payload until its ready is seen.
- Upstream tvalid dropping mid-frame: hold state, no output.

Optional Feature:
- Macro AXIS_FRAME_DEMUX_DROP_COUNT_EN.
- Defined:
  - Adds output port drop_count [15:0], a count of dropped frames.
  - Increments by 1 when the first beat of a frame with tdest>=M_COUNT is accepted.
  - Saturates at 16'hFFFF; reset to 0.
- Not defined: the port is absent and no counter logic is built; drop behaviour is unchanged.

Test Plan:
- Single-beat frame, tdest=2, data 8'hA5, all ready=1 -> m_axis_tvalid=4'b0100 one cycle later, m_axis_tdata slice 2 = 8'hA5, tlast=1; other valid bits stay 0.
- 4-beat frame, tdest=1 on beat 0 and tdest=3 on beats 1-3 -> all 4 beats appear on port 1 in order; port 3 never valid.
- Frame tdest=5 (M_COUNT=4), 3 beats -> s_axis_tready=1 each cycle, no m_axis_tvalid, drop_count=1 with the macro defined.
- Frame to port 0 with m_axis_tready[0]=0 for 5 cycles -> s_axis_tready=0 after 1 beat is buffered; payload is held stable; the frame completes once ready rises and no beat is lost.
- Back-to-back frames to dest 0 then dest 3 with ready=1 -> second frame's first beat accepted the cycle after tlast; valid moves 4'b0001 -> 4'b1000 with no overlap.
- rst pulsed mid-frame in FWD with valid held -> valid bits clear immediately; after release the next beat is treated as a new frame using its tdest.
